// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares the single-port instruction memory between the fetch stage (reads)
// and the loader/debug path (writes). At most one requester is granted per
// cycle. Fetch is protected from starvation by a bounded loader streak, and
// the loader can take exclusive ownership (lock) for program download.
// The memory read latency is one cycle; the arbiter only tracks which cycle
// carries a fetch response and passes the read data straight through.

module imem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    // fetch stage (read-only)
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_flush,
    output logic                  fetch_gnt,
    output logic                  fetch_stall,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,

    // loader / debug write path (write-only)
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_gnt,
    input  logic                  load_lock,
    output logic                  lock_ack,

    // instruction memory port
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    // Counter wide enough to hold 0..STARVE_LIMIT inclusive.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    // OPEN   : normal shared arbitration
    // DRAIN  : lock requested while a fetch response is still in flight;
    //          fetch is blocked for one cycle so the response can land
    // LOCKED : loader owns the memory, fetch is held off entirely
    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             rd_pending;
    logic             fetch_forced;

    // Saturating increment of the loader-streak counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX) begin
            return CNT_MAX;
        end
        return v + 1'b1;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OPEN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a lock request only goes straight to LOCKED when no
    // read response is still due; otherwise one DRAIN cycle absorbs it.
    always_comb begin
        next_state = state;
        case (state)
            ST_OPEN: begin
                if (load_lock) begin
                    next_state = rd_pending ? ST_DRAIN : ST_LOCKED;
                end
            end
            ST_DRAIN: begin
                next_state = load_lock ? ST_LOCKED : ST_OPEN;
            end
            ST_LOCKED: begin
                next_state = load_lock ? ST_LOCKED : ST_OPEN;
            end
            default: begin
                next_state = ST_OPEN;
            end
        endcase
    end

    // Output logic: grants are combinational from requests and registered
    // state. Loader has priority in OPEN unless fetch has waited through a
    // full streak of STARVE_LIMIT loader grants.
    always_comb begin
        fetch_gnt    = 1'b0;
        load_gnt     = 1'b0;
        fetch_forced = fetch_req && (starve_cnt == CNT_MAX);
        case (state)
            ST_OPEN: begin
                if (load_req && !fetch_forced) begin
                    load_gnt = 1'b1;
                end else if (fetch_req) begin
                    fetch_gnt = 1'b1;
                end
            end
            ST_DRAIN, ST_LOCKED: begin
                load_gnt = load_req;
            end
            default: begin
                fetch_gnt = 1'b0;
                load_gnt  = 1'b0;
            end
        endcase
    end

    // Stall is simply a request that did not win this cycle.
    always_comb begin
        fetch_stall = fetch_req && !fetch_gnt;
    end

    // Lock acknowledge is registered so it rises in the first LOCKED cycle
    // and falls in the first cycle back in OPEN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_ack <= 1'b0;
        end else begin
            lock_ack <= (next_state == ST_LOCKED);
        end
    end

    // Streak counter: counts loader grants while fetch keeps waiting. It is
    // forced to zero whenever we are, or are about to be, outside OPEN so a
    // return to OPEN always starts with a fresh streak.
    always_comb begin
        starve_next = starve_cnt;
        if ((state != ST_OPEN) || (next_state != ST_OPEN)) begin
            starve_next = '0;
        end else if (fetch_gnt || !fetch_req) begin
            starve_next = '0;
        end else if (load_gnt) begin
            starve_next = sat_inc(starve_cnt);
        end
    end

    // Streak counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_next;
        end
    end

    // A fetch grant this cycle means the memory returns its word next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= fetch_gnt;
        end
    end

    // Response path: a flush only masks the response landing this cycle;
    // a grant issued alongside the flush returns normally next cycle.
    always_comb begin
        fetch_rvalid = rd_pending && !fetch_flush;
        fetch_rdata  = mem_read_data;
    end

    // Memory port mux; idle drives zeros so the bus is quiet between accesses.
    always_comb begin
        mem_write_en   = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (load_gnt) begin
            mem_write_en   = 1'b1;
            mem_address    = load_addr;
            mem_write_data = load_data;
        end else if (fetch_gnt) begin
            mem_address    = fetch_addr;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table, hand sequences for
// lock/reset corners, and randomized traffic against a behavioural model.

module tb_imem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    localparam int M_OPEN   = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_LOCKED = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_flush;
    logic          fetch_gnt;
    logic          fetch_stall;
    logic          fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          load_req;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_gnt;
    logic          load_lock;
    logic          lock_ack;
    logic          mem_write_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_flush   (fetch_flush),
        .fetch_gnt     (fetch_gnt),
        .fetch_stall   (fetch_stall),
        .fetch_rvalid  (fetch_rvalid),
        .fetch_rdata   (fetch_rdata),
        .load_req      (load_req),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .load_gnt      (load_gnt),
        .load_lock     (load_lock),
        .lock_ack      (lock_ack),
        .mem_write_en  (mem_write_en),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    function automatic int idx(input logic [AW-1:0] a);
        return int'(a & 32'hFF);
    endfunction

    // Synchronous single-port memory, write-before-read across cycles.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] mem_rd;
    always @(posedge clk) begin
        if (mem_write_en) mem[idx(mem_address)] <= mem_write_data;
        mem_rd <= mem[idx(mem_address)];
    end
    assign mem_read_data = mem_rd;

    // ---------------- behavioural reference model ----------------
    int            m_mode;
    int            m_streak;
    bit            m_pend;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] ref_mem [0:255];
    bit            e_fg;
    bit            e_lg;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_OPEN;
        m_streak = 0;
        m_pend   = 1'b0;
    endtask

    task automatic compute_exp();
        e_fg = 1'b0;
        e_lg = 1'b0;
        if (m_mode == M_OPEN) begin
            if (fetch_req && load_req) begin
                if (m_streak >= LIM) e_fg = 1'b1;
                else                 e_lg = 1'b1;
            end else if (fetch_req) begin
                e_fg = 1'b1;
            end else if (load_req) begin
                e_lg = 1'b1;
            end
        end else begin
            e_lg = load_req;
        end
    endtask

    task automatic model_checks();
        bit exp_rv;
        compute_exp();
        exp_rv = m_pend && !fetch_flush;
        check("fetch_gnt", fetch_gnt, e_fg);
        check("load_gnt", load_gnt, e_lg);
        check("fetch_stall", fetch_stall, fetch_req && !e_fg);
        check("lock_ack", lock_ack, m_mode == M_LOCKED);
        check("mem_write_en", mem_write_en, e_lg);
        check("mem_address", mem_address, e_lg ? load_addr : (e_fg ? fetch_addr : '0));
        check("mem_write_data", mem_write_data, e_lg ? load_data : '0);
        check("fetch_rvalid", fetch_rvalid, exp_rv);
        if (exp_rv) check("fetch_rdata", fetch_rdata, m_pend_data);
    endtask

    task automatic model_step();
        int nm;
        case (m_mode)
            M_OPEN:  nm = load_lock ? (m_pend ? M_DRAIN : M_LOCKED) : M_OPEN;
            default: nm = load_lock ? M_LOCKED : M_OPEN;
        endcase
        if (m_mode != M_OPEN || nm != M_OPEN || e_fg || !fetch_req) m_streak = 0;
        else if (e_lg && m_streak < LIM) m_streak = m_streak + 1;
        if (e_lg) ref_mem[idx(load_addr)] = load_data;
        m_pend_data = ref_mem[idx(fetch_addr)];
        m_pend      = e_fg;
        m_mode      = nm;
    endtask

    // Called at a negedge with inputs already driven.
    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit f, input logic [AW-1:0] fa, input bit fl,
                         input bit l, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input bit lk);
        fetch_req   = f;
        fetch_addr  = fa;
        fetch_flush = fl;
        load_req    = l;
        load_addr   = la;
        load_data   = ld;
        load_lock   = lk;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            f;
        logic [AW-1:0] fa;
        bit            fl;
        bit            l;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        bit            lk;
        bit            e_fg;
        bit            e_lg;
        bit            e_ack;
        bit            e_rv;
        bit            chk_d;
        logic [DW-1:0] e_d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit f, logic [AW-1:0] fa, bit fl, bit l, logic [AW-1:0] la,
                                logic [DW-1:0] ld, bit lk, bit efg, bit elg, bit eack,
                                bit erv, bit chk, logic [DW-1:0] ed);
        vec_t v;
        v.f = f; v.fa = fa; v.fl = fl; v.l = l; v.la = la; v.ld = ld; v.lk = lk;
        v.e_fg = efg; v.e_lg = elg; v.e_ack = eack; v.e_rv = erv; v.chk_d = chk; v.e_d = ed;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end

        // fetch only, back to back
        tbl.push_back(mk(1, 'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h04, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h1000_0000));
        tbl.push_back(mk(1, 'h08, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h1000_0004));
        tbl.push_back(mk(1, 'h0C, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h1000_0008));
        tbl.push_back(mk(0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1000_000C));
        tbl.push_back(mk(0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // starvation: 4 loader grants, forced fetch, loader resumes
        tbl.push_back(mk(1, 'h40, 0, 1, 'h80, 32'h0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h40, 0, 1, 'h81, 32'h1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h40, 0, 1, 'h82, 32'h2, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h40, 0, 1, 'h83, 32'h3, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h40, 0, 1, 'h84, 32'h4, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h40, 0, 1, 'h85, 32'h5, 0, 0, 1, 0, 1, 1, 32'h1000_0040));
        // lock with a response in flight: OPEN -> DRAIN -> LOCKED -> OPEN
        tbl.push_back(mk(1, 'h44, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h48, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 32'h1000_0044));
        tbl.push_back(mk(1, 'h48, 0, 1, 'h90, 32'h55, 1, 0, 1, 0, 1, 1, 32'h1000_0048));
        tbl.push_back(mk(1, 'h48, 0, 1, 'h91, 32'h56, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h48, 0, 1, 'h92, 32'h57, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h48, 0, 1, 'h93, 32'h58, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h48, 0, 1, 'h94, 32'h59, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h48, 0, 1, 'h95, 32'h5A, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h48, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 'h20, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // flush masks only the response landing with it
        tbl.push_back(mk(1, 'h24, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1000_0024));
        // write then read the same address
        tbl.push_back(mk(0, 'h00, 0, 1, 'h10, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF));
        // lock dropped during DRAIN: back to OPEN without ack
        tbl.push_back(mk(1, 'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h04, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 32'h1000_0000));
        tbl.push_back(mk(1, 'h08, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1000_0004));
        tbl.push_back(mk(1, 'h08, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1000_0008));

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst fetch_gnt", fetch_gnt, 0);
        check("rst load_gnt", load_gnt, 0);
        check("rst mem_write_en", mem_write_en, 0);
        check("rst mem_address", mem_address, 0);
        check("rst mem_write_data", mem_write_data, 0);
        check("rst fetch_rvalid", fetch_rvalid, 0);
        check("rst lock_ack", lock_ack, 0);
        rst = 1'b0;
        model_reset();

        // ---------------- directed table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].f, tbl[i].fa, tbl[i].fl, tbl[i].l, tbl[i].la, tbl[i].ld, tbl[i].lk);
            #1;
            check($sformatf("v%0d fetch_gnt", i), fetch_gnt, tbl[i].e_fg);
            check($sformatf("v%0d load_gnt", i), load_gnt, tbl[i].e_lg);
            check($sformatf("v%0d fetch_stall", i), fetch_stall, tbl[i].f && !tbl[i].e_fg);
            check($sformatf("v%0d lock_ack", i), lock_ack, tbl[i].e_ack);
            check($sformatf("v%0d fetch_rvalid", i), fetch_rvalid, tbl[i].e_rv);
            if (tbl[i].chk_d) check($sformatf("v%0d fetch_rdata", i), fetch_rdata, tbl[i].e_d);
            model_checks();
            advance();
        end

        // ---------------- async reset while LOCKED with a read in flight ----------------
        drive(1, 'h30, 0, 0, 0, 0, 1);
        #1 model_checks();
        advance();
        #1;
        check("pre-rst lock_ack", lock_ack, 1);
        check("pre-rst fetch_rvalid", fetch_rvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst lock_ack", lock_ack, 0);
        check("async rst fetch_rvalid", fetch_rvalid, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // after release the loader streak starts from zero
        for (int k = 0; k < 6; k++) begin
            drive(1, 'h34, 0, 1, 'hA0 + k, k, 0);
            #1;
            check($sformatf("post-rst fetch_gnt %0d", k), fetch_gnt, k == 4);
            check($sformatf("post-rst lock_ack %0d", k), lock_ack, 0);
            model_checks();
            advance();
        end

        // ---------------- randomized traffic ----------------
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            fetch_req   = ($urandom % 4) != 0;
            fetch_addr  = $urandom;
            fetch_flush = ($urandom % 8) == 0;
            load_req    = ($urandom % 2) != 0;
            load_addr   = $urandom;
            load_data   = $urandom;
            if (($urandom % 24) == 0) load_lock = ~load_lock;
            #1 model_checks();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
